// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU. It keeps one operation in flight
// and holds the response until it is taken. Define ALU_ARB_RR_EN for round-robin arbitration.
module alu_arbiter #(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_req0_valid,
    output logic       o_req0_ready,
    input  logic [7:0] i_req0_a,
    input  logic [7:0] i_req0_b,
    input  logic [3:0] i_req0_op,
    input  logic       i_req1_valid,
    output logic       o_req1_ready,
    input  logic [7:0] i_req1_a,
    input  logic [7:0] i_req1_b,
    input  logic [3:0] i_req1_op,
    output logic [7:0] o_alu_a,
    output logic [7:0] o_alu_b,
    output logic [3:0] o_alu_opcode,
    input  logic [7:0] i_alu_result,
    input  logic       i_alu_carry,
    input  logic       i_alu_zero,
    input  logic       i_alu_overflow,
    input  logic       i_alu_sign,
    output logic       o_rsp_valid,
    input  logic       i_rsp_ready,
    output logic       o_rsp_id,
    output logic [7:0] o_rsp_result,
    output logic [3:0] o_rsp_flags,
    output logic       o_busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e     r_state;
    state_e     w_state_next;
    logic [3:0] r_cnt;
    logic [7:0] r_alu_a;
    logic [7:0] r_alu_b;
    logic [3:0] r_alu_opcode;
    logic       r_rsp_id;
    logic [7:0] r_rsp_result;
    logic [3:0] r_rsp_flags;
    logic       w_idle;
    logic       w_grant;
    logic       w_accept;
    logic       w_capture;

    assign w_idle = (r_state == StIdle);

`ifdef ALU_ARB_RR_EN
    logic r_last;

    // Contested grant goes to whoever was not served last; reset value favours req0 first.
    always_comb begin
        if (i_req0_valid && i_req1_valid) begin
            w_grant = ~r_last;
        end else begin
            w_grant = i_req1_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (w_accept) begin
            r_last <= w_grant;
        end
    end
`else
    always_comb w_grant = i_req1_valid && !i_req0_valid;
`endif

    assign o_req0_ready = w_idle && !w_grant && i_req0_valid;
    assign o_req1_ready = w_idle && w_grant && i_req1_valid;
    assign w_accept     = o_req0_ready || o_req1_ready;
    assign w_capture    = (r_state == StIssue) && (r_cnt == 4'd1);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_state_next = StIssue;
            StIssue: if (w_capture) w_state_next = StResp;
            StResp:  if (i_rsp_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_cnt        <= 4'd0;
            r_alu_a      <= 8'd0;
            r_alu_b      <= 8'd0;
            r_alu_opcode <= 4'd0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= 8'd0;
            r_rsp_flags  <= 4'd0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_cnt        <= 4'(ALU_LAT);
                r_alu_a      <= w_grant ? i_req1_a : i_req0_a;
                r_alu_b      <= w_grant ? i_req1_b : i_req0_b;
                r_alu_opcode <= w_grant ? i_req1_op : i_req0_op;
                r_rsp_id     <= w_grant;
            end else if (r_state == StIssue) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_capture) begin
                r_rsp_result <= i_alu_result;
                r_rsp_flags  <= {i_alu_carry, i_alu_zero, i_alu_overflow, i_alu_sign};
            end
        end
    end

    assign o_alu_a      = r_alu_a;
    assign o_alu_b      = r_alu_b;
    assign o_alu_opcode = r_alu_opcode;
    assign o_rsp_valid  = (r_state == StResp);
    assign o_rsp_id     = r_rsp_id;
    assign o_rsp_result = r_rsp_result;
    assign o_rsp_flags  = r_rsp_flags;
    assign o_busy       = !w_idle;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (ALU_LAT 1 and 3), each with a modelled ALU, checked
// per transaction against an arbitration/latency/result model kept in the bench.
module tb_alu_arbiter;

`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk;
    logic       rst_n     [2];
    logic       vld       [2][2];
    logic [7:0] a_in      [2][2];
    logic [7:0] b_in      [2][2];
    logic [3:0] op_in     [2][2];
    logic       rdy       [2][2];
    logic [7:0] alu_a     [2];
    logic [7:0] alu_b     [2];
    logic [3:0] alu_op    [2];
    logic [11:0] alu_rf   [2];
    logic       rsp_valid [2];
    logic       rsp_ready [2];
    logic       rsp_id    [2];
    logic [7:0] rsp_res   [2];
    logic [3:0] rsp_flags [2];
    logic       busy      [2];

    int lat  [2];
    int last [2];
    int n_cmp;
    int n_err;
    int cur_d;
    bit wiggle;
    logic       obs_id;
    logic [7:0] obs_res;
    logic [3:0] obs_flags;

    // Reference ALU: {result, carry, zero, overflow, sign}; carry on SUB is the borrow.
    function automatic logic [11:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] op);
        logic [8:0] s;
        logic       c;
        logic       v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'd0: begin
                s = {1'b0, a} + {1'b0, b};
                c = s[8];
                v = (a[7] == b[7]) && (s[7] != a[7]);
            end
            4'd1: begin
                s = {1'b0, a} - {1'b0, b};
                c = s[8];
                v = (a[7] != b[7]) && (s[7] != a[7]);
            end
            4'd2:    s = {1'b0, a & b};
            4'd3:    s = {1'b0, a | b};
            4'd4:    s = {1'b0, a ^ b};
            default: s = {1'b0, a};
        endcase
        return {s[7:0], c, (s[7:0] == 8'd0), v, s[7]};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign alu_rf[g] = alu_f(alu_a[g], alu_b[g], alu_op[g]);

        alu_arbiter #(.ALU_LAT(g == 0 ? 1 : 3)) u_dut (
            .clk            (clk),
            .rst_n          (rst_n[g]),
            .i_req0_valid   (vld[g][0]),
            .o_req0_ready   (rdy[g][0]),
            .i_req0_a       (a_in[g][0]),
            .i_req0_b       (b_in[g][0]),
            .i_req0_op      (op_in[g][0]),
            .i_req1_valid   (vld[g][1]),
            .o_req1_ready   (rdy[g][1]),
            .i_req1_a       (a_in[g][1]),
            .i_req1_b       (b_in[g][1]),
            .i_req1_op      (op_in[g][1]),
            .o_alu_a        (alu_a[g]),
            .o_alu_b        (alu_b[g]),
            .o_alu_opcode   (alu_op[g]),
            .i_alu_result   (alu_rf[g][11:4]),
            .i_alu_carry    (alu_rf[g][3]),
            .i_alu_zero     (alu_rf[g][2]),
            .i_alu_overflow (alu_rf[g][1]),
            .i_alu_sign     (alu_rf[g][0]),
            .o_rsp_valid    (rsp_valid[g]),
            .i_rsp_ready    (rsp_ready[g]),
            .o_rsp_id       (rsp_id[g]),
            .o_rsp_result   (rsp_res[g]),
            .o_rsp_flags    (rsp_flags[g]),
            .o_busy         (busy[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (dut%0d): got 0x%0h expected 0x%0h", tag, cur_d, got, exp);
        end
    endtask

    task automatic check_zero(input int d);
        cur_d = d;
        check_eq("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
        check_eq("rst_rsp_id", 32'(rsp_id[d]), 32'd0);
        check_eq("rst_rsp_result", 32'(rsp_res[d]), 32'd0);
        check_eq("rst_rsp_flags", 32'(rsp_flags[d]), 32'd0);
        check_eq("rst_alu_a", 32'(alu_a[d]), 32'd0);
        check_eq("rst_alu_b", 32'(alu_b[d]), 32'd0);
        check_eq("rst_alu_op", 32'(alu_op[d]), 32'd0);
        check_eq("rst_busy", 32'(busy[d]), 32'd0);
    endtask

    // Requester inputs change freely while the block is busy; the block must ignore them.
    task automatic scramble(input int d);
        for (int r = 0; r < 2; r++) begin
            a_in[d][r]  = 8'($urandom);
            b_in[d][r]  = 8'($urandom);
            op_in[d][r] = 4'($urandom_range(0, 5));
            if (wiggle) vld[d][r] = 1'($urandom_range(0, 1));
        end
    endtask

    // Starts just after a rising edge with the DUT idle and at least one requester valid.
    task automatic run_op(input int d, input int hold);
        int          w;
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic [3:0]  eo;
        logic [11:0] ex;
        cur_d = d;
        if (vld[d][0] && vld[d][1]) w = RR ? 1 - last[d] : 0;
        else w = vld[d][1] ? 1 : 0;
        @(negedge clk);
        check_eq("idle_ready0", 32'(rdy[d][0]), 32'(w == 0));
        check_eq("idle_ready1", 32'(rdy[d][1]), 32'(w == 1));
        check_eq("idle_busy", 32'(busy[d]), 32'd0);
        ea = a_in[d][w];
        eb = b_in[d][w];
        eo = op_in[d][w];
        ex = alu_f(ea, eb, eo);
        @(posedge clk);
        last[d] = w;
        for (int k = 0; k < lat[d]; k++) begin
            #1;
            rsp_ready[d] = 1'($urandom_range(0, 1));
            scramble(d);
            @(negedge clk);
            check_eq("issue_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            check_eq("issue_busy", 32'(busy[d]), 32'd1);
            check_eq("issue_ready0", 32'(rdy[d][0]), 32'd0);
            check_eq("issue_ready1", 32'(rdy[d][1]), 32'd0);
            check_eq("issue_alu_a", 32'(alu_a[d]), 32'(ea));
            check_eq("issue_alu_b", 32'(alu_b[d]), 32'(eb));
            check_eq("issue_alu_op", 32'(alu_op[d]), 32'(eo));
            @(posedge clk);
        end
        #1;
        rsp_ready[d] = (hold == 0);
        scramble(d);
        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            if (h == 0) begin
                obs_id    = rsp_id[d];
                obs_res   = rsp_res[d];
                obs_flags = rsp_flags[d];
            end
            check_eq("resp_valid", 32'(rsp_valid[d]), 32'd1);
            check_eq("resp_id", 32'(rsp_id[d]), 32'(w));
            check_eq("resp_result", 32'(rsp_res[d]), 32'(ex[11:4]));
            check_eq("resp_flags", 32'(rsp_flags[d]), 32'(ex[3:0]));
            check_eq("resp_ready0", 32'(rdy[d][0]), 32'd0);
            check_eq("resp_ready1", 32'(rdy[d][1]), 32'd0);
            check_eq("resp_busy", 32'(busy[d]), 32'd1);
            @(posedge clk);
            #1;
            rsp_ready[d] = (h + 1 == hold);
            if (h < hold) scramble(d);
        end
        check_eq("done_rsp_valid", 32'(rsp_valid[d]), 32'd0);
        check_eq("done_busy", 32'(busy[d]), 32'd0);
        check_eq("done_alu_a_held", 32'(alu_a[d]), 32'(ea));
        check_eq("done_alu_op_held", 32'(alu_op[d]), 32'(eo));
    endtask

    task automatic set_req(input int d, input int r, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] op);
        vld[d][r]   = 1'b1;
        a_in[d][r]  = a;
        b_in[d][r]  = b;
        op_in[d][r] = op;
    endtask

    task automatic clear_req(input int d);
        vld[d][0] = 1'b0;
        vld[d][1] = 1'b0;
    endtask

    task automatic random_ops(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            int sel;
            sel = $urandom_range(1, 3);
            for (int r = 0; r < 2; r++) begin
                set_req(d, r, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 5)));
                vld[d][r] = sel[r];
            end
            wiggle = 1'b1;
            run_op(d, $urandom_range(0, 3));
            wiggle = 1'b0;
            clear_req(d);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        wiggle = 1'b0;
        lat[0] = 1;
        lat[1] = 3;
        for (int d = 0; d < 2; d++) begin
            rst_n[d]     = 1'b0;
            rsp_ready[d] = 1'b0;
            last[d]      = 1;
            for (int r = 0; r < 2; r++) begin
                vld[d][r]   = 1'b0;
                a_in[d][r]  = 8'd0;
                b_in[d][r]  = 8'd0;
                op_in[d][r] = 4'd0;
            end
        end
        #2;
        check_zero(0);
        check_zero(1);
        @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(posedge clk);
        #1;

        // Both requesters hold valid across four operations.
        set_req(0, 0, 8'h11, 8'h22, 4'd0);
        set_req(0, 1, 8'h33, 8'h44, 4'd0);
        for (int i = 0; i < 4; i++) begin
            run_op(0, 0);
            check_eq("contested_id_seq", 32'(obs_id), RR ? 32'(i % 2) : 32'd0);
        end
        clear_req(0);

        set_req(0, 0, 8'h0F, 8'h01, 4'd0);
        run_op(0, 0);
        clear_req(0);
        check_eq("add0_id", 32'(obs_id), 32'd0);
        check_eq("add0_result", 32'(obs_res), 32'h10);
        check_eq("add0_flags", 32'(obs_flags), 32'b0000);

        set_req(0, 1, 8'h7F, 8'h01, 4'd0);
        run_op(0, 1);
        clear_req(0);
        check_eq("add1_id", 32'(obs_id), 32'd1);
        check_eq("add1_result", 32'(obs_res), 32'h80);
        check_eq("add1_flags", 32'(obs_flags), 32'b0011);

        random_ops(0, 25);

        // Long response stall on the latency-3 instance with both requesters pending.
        set_req(1, 0, 8'hA5, 8'h5A, 4'd4);
        set_req(1, 1, 8'h01, 8'h02, 4'd3);
        run_op(1, 4);
        clear_req(1);
        check_eq("stall_result", 32'(obs_res), 32'hFF);

        // Reset in the middle of ISSUE.
        cur_d = 1;
        set_req(1, 0, 8'h55, 8'h22, 4'd0);
        @(negedge clk);
        check_eq("pre_rst_ready0", 32'(rdy[1][0]), 32'd1);
        @(posedge clk);
        #1;
        clear_req(1);
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        check_eq("pre_rst_busy", 32'(busy[1]), 32'd1);
        rst_n[1] = 1'b0;
        #1;
        check_zero(1);
        last[1] = 1;
        @(posedge clk);
        @(negedge clk);
        rst_n[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("post_rst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
            check_eq("post_rst_busy", 32'(busy[1]), 32'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready[1] = 1'b0;
        set_req(1, 0, 8'h08, 8'h04, 4'd1);
        run_op(1, 0);
        clear_req(1);
        check_eq("sub_after_rst", 32'(obs_res), 32'h04);

        random_ops(1, 25);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: ALU_LAT, default 1, cycles from driving ALU inputs to capturing ALU outputs; legal range 1..15.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset; the block uses one clock, and reset is asynchronous and active-low.
REQ-004 req0_valid / req1_valid  input  1  requester N has an operation pending.
REQ-005 req0_ready / req1_ready  output  1  requester N's operation is accepted this cycle.
REQ-006 reqN_a, reqN_b  input  8  operands; reqN_op  input  4  ALU opcode.
REQ-007 alu_a, alu_b  output  8; alu_opcode  output  4  drive the shared 8-bit ALU.
REQ-008 alu_result  input  8; alu_carry, alu_zero, alu_overflow, alu_sign  input  1  combinational ALU outputs.
REQ-009 rsp_valid  output  1  response available; rsp_ready  input  1  consumer accepts the response.
REQ-010 rsp_id  output  1  index of the served requester; rsp_result  output  8  captured result.
REQ-011 rsp_flags  output  4  captured {carry, zero, overflow, sign}, carry in bit 3.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 FSM shall have three states: IDLE, ISSUE and RESP; only one operation shall be outstanding at a time.
REQ-014 In IDLE, grant shall be computed combinationally from reqN_valid; reqN_ready = (state==IDLE) && granted N && reqN_valid; ready shall be 0 in all other states.
REQ-015 Accept = valid && ready at a rising edge; on accept, the block shall register the operands, opcode and id, drive them onto alu_a/alu_b/alu_opcode, load the wait counter with ALU_LAT, and move to ISSUE.
REQ-016 In ISSUE, the counter shall decrement each edge; at the edge where the counter==1, the block shall capture alu_result and the flags into the rsp_* registers and move to RESP.
REQ-017 Latency: rsp_valid shall rise exactly ALU_LAT cycles after the accept edge (ALU_LAT=1: the cycle after accept).
REQ-018 In RESP, rsp_valid shall be 1, and rsp_id, rsp_result and rsp_flags shall remain stable until rsp_ready is sampled high; the FSM shall then return to IDLE, and the next accept shall occur no earlier than the following edge.
REQ-019 alu_a, alu_b and alu_opcode shall hold their last issued values in RESP and IDLE, and shall change only on accept.
REQ-020 reqN_* inputs shall be ignored outside the accept cycle; a requester may drop valid before it is accepted without side effects.
REQ-021 rsp_ready high outside RESP shall be ignored.
REQ-022 A single valid requester shall always be granted in IDLE, regardless of arbitration history.

Reset
REQ-023 Asserting rst_n low shall immediately force state=IDLE, counter=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, alu_a=0, alu_b=0, alu_opcode=0, and last-served pointer=1.
REQ-024 Reset during ISSUE or RESP shall discard the in-flight operation, with no response issued; after rst_n rises, the first accept may occur at the first rising edge.

Configuration
REQ-025 Macro ALU_ARB_RR_EN defined: when both requesters are valid in IDLE, grant shall go to the requester not served last, the last-served pointer shall update on every accept, and the first contested grant after reset shall go to req0.
REQ-026 ALU_ARB_RR_EN undefined: fixed priority, with req0 always winning when both are valid, and the last-served pointer shall be absent.

Verification
REQ-027 ALU_LAT=1, req0 ADD (op 0000) a=0x0F b=0x01 -> rsp_valid the cycle after accept, rsp_id=0, rsp_result=0x10, rsp_flags=4'b0000.
REQ-028 req1 ADD a=0x7F b=0x01 -> rsp_result=0x80, rsp_flags=4'b0011 (overflow, sign), rsp_id=1.
REQ-029 ALU_ARB_RR_EN, both requesters hold valid for 4 operations -> rsp_id sequence 0,1,0,1; undefined -> 0,0,0,0, and req1_ready never 1.
REQ-030 ALU_LAT=3, rsp_ready held low 4 cycles in RESP -> rsp_valid rises 3 cycles after accept, rsp_* stable throughout, both readies 0, busy=1.
REQ-031 rst_n pulsed low during ISSUE -> rsp_valid stays 0, all outputs 0 immediately; after reset, req0 SUB a=0x08 b=0x04 -> rsp_result=0x04.
